fetch_queue: RTL

Parametrised instruction-fetch front end with a DEPTH-entry instruction queue between the instruction cache/memory port and the decoder. It keeps at most one fetch outstanding, prefetches sequentially while queue space remains, and redirects on JAL inside fetch. It stalls on JALR until execute resolves the target, and flushes on branch misprediction, discarding any stale in-flight response.

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetch_queue_fifo.sv | 78 +++++++
 rtl/fetch_queue.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: opcode constants,
// FSM state encoding, sequential PC increment and the JAL offset helper.
// Optional feature macro: FETCH_JAL_REDIRECT_EN (JAL redirected inside fetch).
package fetch_queue_pkg;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Byte distance between sequential instructions.
    localparam int unsigned PC_INC = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WAITJ = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_e;

`ifdef FETCH_JAL_REDIRECT_EN
    // Reassemble the 21-bit J-type immediate (bit 0 always zero).
    function automatic logic [20:0] jal_offset(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction
`endif

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of DEPTH entries holding {pc, instruction} pairs.
// Push and pop may coincide (also when full); clear empties the buffer and
// takes priority over push/pop. o_count_nxt exposes the occupancy after the
// current edge so the fetch FSM can decide on a new request one cycle early.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH):0]   o_count_nxt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;
    logic [CNT_W-1:0] w_count_nxt;

    // A pop needs a valid head; a push needs a free slot unless a pop frees one.
    assign w_do_pop  = i_pop & (r_count != {CNT_W{1'b0}});
    assign w_do_push = i_push & ((r_count < CNT_W'(DEPTH)) | w_do_pop);

    // Occupancy after this edge.
    always_comb begin
        w_count_nxt = r_count;
        if (i_clear) begin
            w_count_nxt = {CNT_W{1'b0}};
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1'b1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1'b1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointer, count and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= {PTR_W{1'b0}};
            r_wr    <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (i_clear) begin
            r_rd    <= {PTR_W{1'b0}};
            r_wr    <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + PTR_W'(1'b1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + PTR_W'(1'b1);
            end
            r_count <= w_count_nxt;
        end
    end

    assign o_data      = r_mem[r_rd];
    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: keeps one fetch outstanding, prefetches
// sequentially into a DEPTH-entry queue, stalls on JALR until execute
// supplies the target and flushes on misprediction, dropping a stale
// in-flight response. With FETCH_JAL_REDIRECT_EN defined, JAL targets are
// computed here; otherwise JAL waits for jr_en like JALR.
// ic_req is a registered pulse decided from the post-edge state, so a
// redirect (jr_en, flush, dropped response) requests on the next cycle, while
// a response cycle never issues, giving one hit every two cycles.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          INST_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    output logic                ic_req,
    output logic [ADDR_W-1:0]   ic_addr,
    input  logic                ic_valid,
    input  logic [INST_W-1:0]   ic_inst,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [ADDR_W-1:0]   dec_pc,
    output logic [INST_W-1:0]   dec_inst,
    input  logic                jr_en,
    input  logic [ADDR_W-1:0]   jr_addr,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   flush_addr
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e        r_state;
    fetch_state_e        w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                r_pend;
    logic                w_pend_nxt;
    logic                r_ic_req;
    logic [ADDR_W-1:0]   r_ic_addr;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_clear;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [6:0]          w_opcode;
    logic [ADDR_W-1:0]   w_pc_seq;
    logic [ADDR_W+INST_W-1:0] w_fifo_out;

    assign w_opcode = ic_inst[6:0];
    assign w_pc_seq = r_pc + ADDR_W'(PC_INC);

`ifdef FETCH_JAL_REDIRECT_EN
    logic [20:0]         w_jal_off;
    logic [ADDR_W-1:0]   w_jal_tgt;
    assign w_jal_off = jal_offset(ic_inst[31:0]);
    assign w_jal_tgt = r_pc + {{(ADDR_W-21){w_jal_off[20]}}, w_jal_off};
`endif

    // Next state, next pc, pending flag and queue push/clear.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_push      = 1'b0;
        w_clear     = 1'b0;
        if (!rdy) begin
            w_state_nxt = r_state;
        end else if (r_state == S_IDLE) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = RESET_PC;
            w_pend_nxt  = 1'b0;
        end else if (flush) begin
            // Flush wins; a response still in flight must be swallowed later.
            w_clear  = 1'b1;
            w_pc_nxt = flush_addr;
            if (r_pend && !ic_valid) begin
                w_state_nxt = S_DROP;
            end else begin
                w_state_nxt = S_RUN;
                w_pend_nxt  = 1'b0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_pend && ic_valid) begin
                        w_push     = 1'b1;
                        w_pend_nxt = 1'b0;
                        if (w_opcode == OP_JALR) begin
                            w_state_nxt = S_WAITJ;
`ifdef FETCH_JAL_REDIRECT_EN
                        end else if (w_opcode == OP_JAL) begin
                            w_pc_nxt = w_jal_tgt;
`else
                        end else if (w_opcode == OP_JAL) begin
                            w_state_nxt = S_WAITJ;
`endif
                        end else begin
                            w_pc_nxt = w_pc_seq;
                        end
                    end else begin
                        w_pend_nxt = r_pend;
                    end
                end
                S_WAITJ: begin
                    if (jr_en) begin
                        w_pc_nxt    = jr_addr;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_WAITJ;
                    end
                end
                S_DROP: begin
                    if (ic_valid) begin
                        w_state_nxt = S_RUN;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_DROP;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_pend_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign w_pop = rdy & dec_valid & dec_ready;

    // Request decision: running after this edge, nothing outstanding, room in
    // the queue, and not the cycle that just accepted a response.
    always_comb begin
        w_issue = 1'b0;
        if (rdy && (r_state != S_IDLE) && (w_state_nxt == S_RUN) &&
            !w_pend_nxt && !w_push && (w_count_nxt < CNT_W'(DEPTH))) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    // FSM, pc, pending flag and request output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_pend    <= 1'b0;
            r_ic_req  <= 1'b0;
            r_ic_addr <= RESET_PC;
        end else if (rdy) begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_pend   <= w_pend_nxt | w_issue;
            r_ic_req <= w_issue;
            if (w_issue) begin
                r_ic_addr <= w_pc_nxt;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_clear     (w_clear),
        .i_data      ({r_pc, ic_inst}),
        .o_data      (w_fifo_out),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt)
    );

    assign ic_req    = r_ic_req & rdy;
    assign ic_addr   = r_ic_addr;
    assign dec_valid = (w_count != {CNT_W{1'b0}});
    assign dec_pc    = w_fifo_out[ADDR_W+INST_W-1:INST_W];
    assign dec_inst  = w_fifo_out[INST_W-1:0];

endmodule
